// File: rtl/vector_sweeper_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vector_sweeper_pkg
//  Description : Shared types and helpers for the exhaustive vector sweeper.
//                - state_t  : sweep controller states
//                - c_HOLD_W : width of the per-vector hold counter
//                - bin2gray : reflected Gray encoding of a step index
//  Revision    : 1.0  initial release
// ============================================================================
package vector_sweeper_pkg;

    localparam int c_HOLD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Reflected Gray code; wide enough for any legal step index (N+1 <= 7).
    function automatic logic [7:0] bin2gray(input logic [7:0] idx);
        return idx ^ (idx >> 1);
    endfunction

endpackage : vector_sweeper_pkg
`default_nettype wire

// File: rtl/vector_sweeper_hold_timer.sv
`default_nettype none
// ============================================================================
//  Module      : hold_timer
//  Description : Free-running modulo-HOLD counter that flags the last cycle
//                of each hold window.
//  Ports       : clk  in  rising-edge clock
//                rst  in  synchronous active-high reset
//                clr  in  forces the count back to 0
//                tick out high while the count equals HOLD-1
//  Revision    : 1.0  initial release
// ============================================================================
module hold_timer
    import vector_sweeper_pkg::*;
#(
    parameter int HOLD = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam logic [c_HOLD_W-1:0] c_LAST = c_HOLD_W'(HOLD - 1);

    logic [c_HOLD_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (r_count == c_LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_HOLD_W'(1);
        end
    end

    // With HOLD=1 the count is pinned at 0, so tick is high every cycle.
    assign tick = (r_count == c_LAST);

endmodule : hold_timer
`default_nettype wire

// File: rtl/vector_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : vector_sweeper
//  Description : Walks every N-bit vector (binary or Gray order), holds each
//                for HOLD cycles, captures the M-bit response on the last
//                hold cycle and assembles the full truth table.
//  Ports       : clk    in   rising-edge clock
//                rst    in   synchronous active-high reset
//                start  in   begins a sweep from IDLE or DONE
//                vec    out  N      vector driven to the unit under test
//                resp   in   M      unit response
//                sample out  strobe on the capture cycle
//                busy   out  high while sweeping
//                done   out  high after completion until start/rst
//                tt     out  M*2^N  truth table, tt[v*M +: M] = resp(v)
//  Revision    : 1.0  initial release
// ============================================================================
module vector_sweeper
    import vector_sweeper_pkg::*;
#(
    parameter int N    = 3,
    parameter int M    = 1,
    parameter int HOLD = 20,
    parameter int GRAY = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [N-1:0]          vec,
    input  logic [M-1:0]          resp,
    output logic                  sample,
    output logic                  busy,
    output logic                  done,
    output logic [M*(2**N)-1:0]   tt
);

    localparam int           c_NVEC     = 2 ** N;
    localparam int           c_TT_W     = M * c_NVEC;
    // idx carries one spare bit so the terminal compare can never wrap.
    localparam logic [N:0]   c_LAST_IDX = (N + 1)'(c_NVEC - 1);

    state_t              r_state;
    logic [N:0]          r_idx;
    logic [N-1:0]        r_vec;
    logic [c_TT_W-1:0]   r_tt;
    logic                r_busy;
    logic                r_done;

    logic                w_tick;
    logic                w_clr;
    logic [N:0]          w_idx_nxt;
    logic [N-1:0]        w_vec_nxt;

    // The timer only counts while sweeping, so every sweep starts at count 0.
    assign w_clr = (r_state != DRIVE);

    hold_timer #(
        .HOLD (HOLD)
    ) u_hold_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .tick (w_tick)
    );

    assign w_idx_nxt = r_idx + (N + 1)'(1);

    // vec is registered from the next index so it changes with idx.
    generate
        if (GRAY != 0) begin : g_gray
            assign w_vec_nxt = N'(bin2gray(8'(w_idx_nxt)));
        end else begin : g_binary
            assign w_vec_nxt = w_idx_nxt[N-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_vec   <= '0;
            r_tt    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= DRIVE;
                        r_idx   <= '0;
                        r_vec   <= '0;
                        r_tt    <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                DRIVE: begin
                    // start is deliberately not looked at here.
                    if (w_tick) begin
                        // Stored by vector value, not by step, so Gray order
                        // yields the same table as binary order.
                        r_tt[r_vec*M +: M] <= resp;
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= w_idx_nxt;
                            r_vec <= w_vec_nxt;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Decoded from registered state and count, so it is clean for the
    // whole capture cycle.
    assign sample = (r_state == DRIVE) && w_tick;
    assign vec    = r_vec;
    assign busy   = r_busy;
    assign done   = r_done;
    assign tt     = r_tt;

endmodule : vector_sweeper
`default_nettype wire

// File: tb/tb_vector_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vector_sweeper
//  Description : Self-checking bench for vector_sweeper. Three instances:
//                A: N=3 M=1 HOLD=20 binary, B: same in Gray order,
//                C: N=2 M=2 HOLD=1. Each unit under test is a lookup table
//                held by the bench; expected outputs are derived from the
//                elapsed cycles since an accepted start.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vector_sweeper;

    logic       clk;
    logic       rst;
    bit         start_s [3];
    logic       start_a, start_b, start_c;
    logic [2:0] vec_a, vec_b;
    logic [1:0] vec_c;
    logic       resp_a, resp_b;
    logic [1:0] resp_c;
    logic       sample_a, sample_b, sample_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
    logic [7:0] tt_a, tt_b, tt_c;

    int lut  [3][64];
    int snap [3][64];
    int j    [3];
    int n_checks;
    int n_pass;

    logic [63:0] st_g [3];
    logic [63:0] tt_g [3];

    assign start_a = start_s[0];
    assign start_b = start_s[1];
    assign start_c = start_s[2];

    assign resp_a = lut[0][vec_a][0];
    assign resp_b = lut[1][vec_b][0];
    assign resp_c = lut[2][vec_c][1:0];

    assign st_g[0] = 64'({busy_a, done_a, sample_a, 8'(vec_a)});
    assign st_g[1] = 64'({busy_b, done_b, sample_b, 8'(vec_b)});
    assign st_g[2] = 64'({busy_c, done_c, sample_c, 8'(vec_c)});
    assign tt_g[0] = 64'(tt_a);
    assign tt_g[1] = 64'(tt_b);
    assign tt_g[2] = 64'(tt_c);

    vector_sweeper #(.N(3), .M(1), .HOLD(20), .GRAY(0)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .vec(vec_a), .resp(resp_a),
        .sample(sample_a), .busy(busy_a), .done(done_a), .tt(tt_a)
    );

    vector_sweeper #(.N(3), .M(1), .HOLD(20), .GRAY(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .vec(vec_b), .resp(resp_b),
        .sample(sample_b), .busy(busy_b), .done(done_b), .tt(tt_b)
    );

    vector_sweeper #(.N(2), .M(2), .HOLD(1), .GRAY(0)) u_dut_c (
        .clk(clk), .rst(rst), .start(start_c), .vec(vec_c), .resp(resp_c),
        .sample(sample_c), .busy(busy_c), .done(done_c), .tt(tt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-instance configuration.
    function automatic int n_of(int d); return (d == 2) ? 2 : 3;  endfunction
    function automatic int m_of(int d); return (d == 2) ? 2 : 1;  endfunction
    function automatic int h_of(int d); return (d == 2) ? 1 : 20; endfunction
    function automatic int g_of(int d); return (d == 1) ? 1 : 0;  endfunction
    function automatic int len_of(int d); return (1 << n_of(d)) * h_of(d); endfunction

    // k-th vector of the sweep order.
    function automatic int ord(int k, int gray);
        return (gray != 0) ? (k ^ (k >> 1)) : k;
    endfunction

    // Expected {busy, done, sample, vec} for cycle j[d] after start.
    function automatic logic [63:0] exp_stat(int d);
        int  len;
        int  k;
        bit  b;
        bit  s;
        len = len_of(d);
        if (j[d] == 0) return 64'd0;
        b = (j[d] <= len);
        s = b && ((j[d] % h_of(d)) == 0);
        k = b ? (j[d] - 1) / h_of(d) : (1 << n_of(d)) - 1;
        return 64'({b, !b, s, 8'(ord(k, g_of(d)))});
    endfunction

    // Expected table: every vector whose hold window has already closed.
    function automatic logic [63:0] exp_tt(int d);
        logic [63:0] t;
        int          s;
        int          v;
        t = 64'd0;
        if (j[d] == 0) return t;
        s = (j[d] - 1) / h_of(d);
        if (s > (1 << n_of(d))) s = 1 << n_of(d);
        for (int k = 0; k < s; k++) begin
            v = ord(k, g_of(d));
            t = t | (64'(snap[d][v]) << (v * m_of(d)));
        end
        return t;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: update the model at the edge, compare at the falling edge.
    task automatic cycle();
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                j[d] = 0;
            end else if (start_s[d] && (j[d] == 0 || j[d] > len_of(d))) begin
                j[d] = 1;
                for (int v = 0; v < 64; v++) snap[d][v] = lut[d][v];
            end else if (j[d] > 0 && j[d] <= len_of(d)) begin
                j[d] = j[d] + 1;
            end
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("stat%0d_j%0d", d, j[d]), st_g[d], exp_stat(d));
            check($sformatf("tt%0d_j%0d", d, j[d]), tt_g[d], exp_tt(d));
        end
    endtask

    task automatic set_starts(input bit s);
        for (int d = 0; d < 3; d++) start_s[d] = s;
    endtask

    task automatic run_until_done();
        int c;
        c = 0;
        while (!(done_a && done_b && done_c) && c < 400) begin
            cycle();
            c++;
        end
        check("sweep_end", 64'(done_a && done_b && done_c), 64'd1);
    endtask

    function automatic int majority(int v);
        int a, b, c;
        a = v & 1; b = (v >> 1) & 1; c = (v >> 2) & 1;
        return (a & b) | (a & c) | (b & c);
    endfunction

    initial begin
        int cnt;
        int busy_cnt;
        bit hold_c;

        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        set_starts(1'b0);
        for (int d = 0; d < 3; d++) j[d] = 0;
        for (int v = 0; v < 64; v++) begin
            lut[0][v] = majority(v);
            lut[1][v] = majority(v);
            lut[2][v] = ((((v >> 1) & v) & 1) << 1) | (((v >> 1) ^ v) & 1);
            for (int d = 0; d < 3; d++) snap[d][v] = 0;
        end

        repeat (3) cycle();
        check("reset_tt_a", tt_g[0], 64'd0);
        rst = 1'b0;
        cycle();

        // Majority sweep; start re-pulsed mid-run on A and B must be ignored.
        set_starts(1'b1);
        cycle();
        set_starts(1'b0);
        cnt      = 1;
        busy_cnt = busy_a ? 1 : 0;
        while (!done_a && cnt < 400) begin
            start_s[0] = (cnt == 40);
            start_s[1] = (cnt == 40);
            cycle();
            cnt++;
            if (busy_a) busy_cnt++;
        end
        set_starts(1'b0);
        check("done_latency", 64'(cnt), 64'd161);
        check("busy_len", 64'(busy_cnt), 64'd160);
        check("maj_bin_tt", tt_g[0], 64'hE8);
        check("maj_gray_tt", tt_g[1], 64'hE8);
        check("hold1_tt", tt_g[2], 64'h94);

        // Restart from DONE: table clears, second sweep gives the same table.
        set_starts(1'b1);
        cycle();
        set_starts(1'b0);
        check("restart_done_low", 64'(done_a), 64'd0);
        check("restart_tt_clear", tt_g[0], 64'd0);
        run_until_done();
        check("resweep_bin_tt", tt_g[0], 64'hE8);
        check("resweep_gray_tt", tt_g[1], 64'hE8);
        check("resweep_hold1_tt", tt_g[2], 64'h94);

        // Reset at cycle 50 of a sweep with a nonzero early response.
        lut[0][0] = 1;
        lut[1][0] = 1;
        set_starts(1'b1);
        cycle();
        set_starts(1'b0);
        repeat (49) cycle();
        check("pre_rst_tt_a", tt_g[0], 64'h01);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_vec", 64'(vec_a), 64'd0);
        check("rst_tt", tt_g[0], 64'd0);
        set_starts(1'b1);
        cycle();
        set_starts(1'b0);
        check("post_rst_vec0", 64'(vec_b), 64'd0);
        run_until_done();
        check("post_rst_tt_a", tt_g[0], 64'hE9);
        check("post_rst_tt_b", tt_g[1], 64'hE9);

        // Random units, random ignored starts, optional back-to-back on C.
        for (int it = 0; it < 6; it++) begin
            for (int v = 0; v < 64; v++) begin
                lut[0][v] = int'($urandom_range(0, 1));
                lut[1][v] = int'($urandom_range(0, 1));
                lut[2][v] = int'($urandom_range(0, 3));
            end
            hold_c = 1'($urandom_range(0, 1));
            set_starts(1'b1);
            cycle();
            for (int c = 1; c <= 170; c++) begin
                start_s[0] = (c < 150) && ($urandom_range(0, 7) == 0);
                start_s[1] = (c < 150) && ($urandom_range(0, 7) == 0);
                start_s[2] = hold_c && (c < 100);
                cycle();
            end
            set_starts(1'b0);
            check($sformatf("rand%0d_done", it), 64'({done_a, done_b, done_c}), 64'h7);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_vector_sweeper
`default_nettype wire
